// File: rtl/uart_tx_sched.sv
// Round-robin front end that funnels NREQ byte producers through a FIFO into a
// single UART transmitter. A sequencer launches one frame at a time and enforces an inter-frame gap.
module uart_tx_sched #(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 8,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_trans_en,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_timeout,
  output logic [15:0]              sent_count
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  state_t          state_reg;
  logic            tx_en_reg;
  logic [7:0]      tx_data_reg;
  logic            err_reg;
  logic [15:0]     sent_reg;
  logic [TW-1:0]   tmo_cnt_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic [IW-1:0]   rr_reg;
  logic [IW-1:0]   rr_next;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [7:0]      mem [DEPTH];

  logic [7:0]      req_byte [NREQ];
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand;
  logic            push;
  logic            pop;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  // Rotating priority search starting at rr_reg; a full FIFO suppresses every grant.
  always_comb begin
    grant  = '0;
    winner = '0;
    cand   = '0;
    push   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(rr_reg) + k) % NREQ);
      if (!push && req_valid[cand]) begin
        push        = 1'b1;
        grant[cand] = 1'b1;
        winner      = cand;
      end
    end
    if (level_reg == FULL_LEVEL) begin
      grant = '0;
      push  = 1'b0;
    end
  end

  assign rr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
  assign pop     = (state_reg == IDLE) && enable && (level_reg != '0) && !tx_busy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= req_byte[winner];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      rr_reg     <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        rr_reg     <= rr_next;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      level_reg <= level_reg + 1'b1;
      else if (pop && !push) level_reg <= level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg   <= IDLE;
      tx_en_reg   <= 1'b0;
      tx_data_reg <= '0;
      err_reg     <= 1'b0;
      sent_reg    <= '0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            tx_data_reg <= mem[rd_ptr_reg];
            tx_en_reg   <= 1'b1;
            tmo_cnt_reg <= '0;
            state_reg   <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (tx_busy) begin
            tx_en_reg <= 1'b0;
            state_reg <= BUSY;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            // Engine never answered: the byte already left the FIFO and is dropped.
            tx_en_reg <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        BUSY: begin
          if (!tx_busy) begin
            sent_reg    <= sent_reg + 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= (GAP_CYC == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) state_reg <= IDLE;
          else gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Grants are masked while reset is held so no transfer is offered during reset.
  assign req_ready   = rstN ? grant : '0;
  assign tx_trans_en = tx_en_reg;
  assign tx_data     = tx_data_reg;
  assign fifo_level  = level_reg;
  assign err_timeout = err_reg;
  assign sent_count  = sent_reg;

endmodule
